vga_object_motion_ctrl: RTL and testbench
=========================================

Name: vga_object_motion_ctrl

Overview:
Per-frame sequencer for the VGA square-object datapath. Holds the position and direction of one 40x40 square and moves it by a programmable step once per N frames. Updates happen only during vertical blanking, and the square bounces off the active-area edges. It also produces the registered pixel hit and RGB drive fed to VGA_controller iRed/iGreen/iBlue, replacing the fixed-position object logic in the top level.

Parameters:
OBJ_SIZE, 40, square edge length in pixels
H_ACTIVE, 640, active columns
V_ACTIVE, 480, active rows; pixel_y >= V_ACTIVE means vertical blanking
INIT_X, 300, reset column of the top-left corner
INIT_Y, 220, reset row of the top-left corner
FRAME_DIV, 1, frames per movement update (>= 1)

Ports:
clock  in  1  50 MHz system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  25 MHz pixel tick (high every other clock)
pixel_x  in  10  current column from VGA_controller oCoord_X
pixel_y  in  10  current row from VGA_controller oCoord_Y
pause  in  1  freezes motion when high
step  in  3  pixels moved per update on each axis; 0 means no motion
obj_x  out  10  current top-left column
obj_y  out  10  current top-left row
dir_x  out  1  1 = moving right, 0 = moving left
dir_y  out  1  1 = moving down, 0 = moving up
obj_on  out  1  registered pixel-inside-square flag
red, green, blue  out  8 each  registered pixel colour
frame_count  out  8  frames seen since reset, wraps at 255 -> 0

Behaviour:
- Reset values: obj_x = INIT_X, obj_y = INIT_Y, dir_x = 1, dir_y = 1, obj_on = 0, RGB = 0, frame_count = 0, div_cnt = 0, state = WAIT_ACTIVE.
- FSM: WAIT_ACTIVE, ARMED, UPDATE_X, UPDATE_Y.
- WAIT_ACTIVE -> ARMED when pixel_y < V_ACTIVE. This prevents an update in a partially seen blanking interval after reset.
- ARMED -> UPDATE_X when enable && pixel_y >= V_ACTIVE. On this transition:
  - frame_count increments.
  - If pause = 0, div_cnt advances. div_cnt wraps to 0 when it reaches FRAME_DIV-1; that wrap sets internal flag do_move. When pause = 1, div_cnt holds and do_move = 0.
- UPDATE_X (1 clock) -> UPDATE_Y (1 clock) -> WAIT_ACTIVE. Axis updates only when do_move = 1. All arithmetic is 11-bit unsigned.
  - dir_x = 1: if obj_x + step + OBJ_SIZE > H_ACTIVE, then obj_x = H_ACTIVE - OBJ_SIZE and dir_x = 0. Otherwise obj_x += step.
  - dir_x = 0: if obj_x < step, then obj_x = 0 and dir_x = 1. Otherwise obj_x -= step.
  - Y axis uses the same rules with V_ACTIVE and dir_y.
  - step = 0: position and direction are unchanged.
  - Exact edge landing (obj_x + step + OBJ_SIZE == H_ACTIVE) moves without reversing. The reversal happens on the next update.
- Exactly one update per frame regardless of how long blanking lasts.
- Position never changes while pixel_y < V_ACTIVE, so there is no tearing.
- Pixel path is registered and advances only when enable = 1; it holds otherwise.
  - obj_on <= (pixel_x >= obj_x) && (pixel_x < obj_x + OBJ_SIZE) && (pixel_y >= obj_y) && (pixel_y < obj_y + OBJ_SIZE).
  - RGB <= FF/FF/FF when inside the square, 00/00/00 otherwise.
  - Latency is one enable cycle from coordinate to colour.
- pause or step changes take effect at the next ARMED -> UPDATE_X transition.
- Reset mid-operation (any state) returns every register to its reset value immediately.

Test Plan:
- Reset, step = 1, pause = 0, FRAME_DIV = 1, run 3 frames -> obj_x = 303, obj_y = 223, frame_count = 3, dir_x = dir_y = 1.
- Set obj_x = 597 (let the object run there), step = 4 -> next update obj_x = 600, dir_x = 0; the following update gives obj_x = 596.
- Left edge: obj_x = 2, dir_x = 0, step = 5 -> obj_x = 0, dir_x = 1. Bottom: obj_y = 438, dir_y = 1, step = 3 -> obj_y = 440, dir_y = 0.
- FRAME_DIV = 3, step = 2, 6 frames -> exactly 2 moves, obj_x = 304. pause = 1 for 4 frames -> obj_x and div_cnt frozen, frame_count still +4.
- Drive pixel (300,220) at reset position with enable -> obj_on = 1 and RGB = FFFFFF one enable later. Drive (340,220) -> obj_on = 0 and RGB = 000000. With enable = 0 the outputs hold.
- Assert reset while pixel_y = 500 in UPDATE_X -> all outputs at reset values. Release while pixel_y = 500 -> no update until pixel_y drops below 480 and blanking starts again.

Source files
------------

// File: rtl/vga_object_motion_ctrl.sv
// Moves a 40x40 square once per FRAME_DIV frames during vertical blanking,
// bouncing off the active-area edges, and drives registered pixel colour.
module vga_object_motion_ctrl #(
   parameter int OBJ_SIZE  = 40,
   parameter int H_ACTIVE  = 640,
   parameter int V_ACTIVE  = 480,
   parameter int INIT_X    = 300,
   parameter int INIT_Y    = 220,
   parameter int FRAME_DIV = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   input  logic       pause,
   input  logic [2:0] step,
   output logic [9:0] obj_x,
   output logic [9:0] obj_y,
   output logic       dir_x,
   output logic       dir_y,
   output logic       obj_on,
   output logic [7:0] red,
   output logic [7:0] green,
   output logic [7:0] blue,
   output logic [7:0] frame_count
);

   localparam logic [1:0] WAIT_ACTIVE = 2'd0;
   localparam logic [1:0] ARMED       = 2'd1;
   localparam logic [1:0] UPDATE_X    = 2'd2;
   localparam logic [1:0] UPDATE_Y    = 2'd3;

   localparam logic [10:0] SIZE_11  = 11'(OBJ_SIZE);
   localparam logic [10:0] H_11     = 11'(H_ACTIVE);
   localparam logic [10:0] V_11     = 11'(V_ACTIVE);
   localparam logic [7:0]  DIV_LAST = 8'(FRAME_DIV - 1);

   logic [1:0]  state_r;
   logic [1:0]  state_next_s;
   logic [7:0]  div_cnt_r;
   logic        do_move_r;
   logic [2:0]  step_r;
   logic        blank_s;
   logic        arm_fire_s;
   logic        hit_s;
   logic [10:0] px_s;
   logic [10:0] py_s;
   logic [10:0] ox_s;
   logic [10:0] oy_s;

   // Returns {new_dir, new_pos}; clamps to the edge and reverses on overshoot.
   function automatic logic [10:0] axis_next(input logic [9:0] pos, input logic dir,
                                             input logic [2:0] stp, input logic [10:0] limit);
      logic [10:0] p;
      logic [10:0] s;
      logic [10:0] r;
      p = {1'b0, pos};
      s = {8'd0, stp};
      if (dir) begin
         if (p + s + SIZE_11 > limit) begin
            r = {1'b0, 10'(limit - SIZE_11)};
         end else begin
            r = {1'b1, 10'(p + s)};
         end
      end else begin
         if (p < s) begin
            r = {1'b1, 10'd0};
         end else begin
            r = {1'b0, 10'(p - s)};
         end
      end
      return r;
   endfunction

   assign px_s       = {1'b0, pixel_x};
   assign py_s       = {1'b0, pixel_y};
   assign ox_s       = {1'b0, obj_x};
   assign oy_s       = {1'b0, obj_y};
   assign blank_s    = (py_s >= V_11);
   assign arm_fire_s = (state_r == ARMED) && enable && blank_s;
   assign hit_s      = (px_s >= ox_s) && (px_s < ox_s + SIZE_11) &&
                       (py_s >= oy_s) && (py_s < oy_s + SIZE_11);

   // Next-state logic for the per-frame sequencer.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         WAIT_ACTIVE: begin
            if (!blank_s) begin
               state_next_s = ARMED;
            end else begin
               state_next_s = WAIT_ACTIVE;
            end
         end
         ARMED: begin
            if (arm_fire_s) begin
               state_next_s = UPDATE_X;
            end else begin
               state_next_s = ARMED;
            end
         end
         UPDATE_X: state_next_s = UPDATE_Y;
         UPDATE_Y: state_next_s = WAIT_ACTIVE;
         default:  state_next_s = WAIT_ACTIVE;
      endcase
   end

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= WAIT_ACTIVE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Frame counting, divider and step capture at the start of blanking.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         frame_count <= 8'd0;
         div_cnt_r   <= 8'd0;
         do_move_r   <= 1'b0;
         step_r      <= 3'd0;
      end else if (arm_fire_s) begin
         frame_count <= frame_count + 8'd1;
         step_r      <= step;
         if (pause) begin
            do_move_r <= 1'b0;
         end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= 8'd0;
            do_move_r <= 1'b1;
         end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
            do_move_r <= 1'b0;
         end
      end
   end

   // Position and direction update, one axis per clock.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         obj_x <= 10'(INIT_X);
         obj_y <= 10'(INIT_Y);
         dir_x <= 1'b1;
         dir_y <= 1'b1;
      end else if (do_move_r && (state_r == UPDATE_X)) begin
         {dir_x, obj_x} <= axis_next(obj_x, dir_x, step_r, H_11);
      end else if (do_move_r && (state_r == UPDATE_Y)) begin
         {dir_y, obj_y} <= axis_next(obj_y, dir_y, step_r, V_11);
      end
   end

   // Registered pixel hit and colour, advancing on the pixel tick.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         obj_on <= 1'b0;
         red    <= 8'h00;
         green  <= 8'h00;
         blue   <= 8'h00;
      end else if (enable) begin
         obj_on <= hit_s;
         red    <= hit_s ? 8'hFF : 8'h00;
         green  <= hit_s ? 8'hFF : 8'h00;
         blue   <= hit_s ? 8'hFF : 8'h00;
      end
   end

endmodule

// File: tb/tb_vga_object_motion_ctrl.sv
// Randomized scoreboard bench: two instances (FRAME_DIV 1 and 3) share stimulus
// and are checked against a per-frame bounce model and a pixel-hit model.
module tb_vga_object_motion_ctrl;

   logic       clock = 1'b0;
   logic       reset;
   logic       enable;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       pause;
   logic [2:0] step;

   logic [9:0] ox0, oy0, ox1, oy1;
   logic       dx0, dy0, dx1, dy1, on0, on1;
   logic [7:0] r0, g0, b0, r1, g1, b1, fc0, fc1;

   typedef struct packed {
      logic [7:0] fc;
      logic [9:0] x;
      logic [9:0] y;
      logic       dx;
      logic       dy;
   } mv_t;

   typedef struct packed {
      logic        on0;
      logic [23:0] rgb0;
      logic        on1;
      logic [23:0] rgb1;
   } px_t;

   mv_t mq0[$];
   mv_t mq1[$];
   px_t pq[$];

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   int mx[2], my[2], mdx[2], mdy[2], mcnt[2];
   int fdv[2] = '{1, 3};
   int mfc;
   bit armed;

   always #10 clock = ~clock;

   vga_object_motion_ctrl #(.FRAME_DIV(1)) dut0 (
      .clock(clock), .reset(reset), .enable(enable), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .pause(pause), .step(step), .obj_x(ox0), .obj_y(oy0), .dir_x(dx0), .dir_y(dy0),
      .obj_on(on0), .red(r0), .green(g0), .blue(b0), .frame_count(fc0));

   vga_object_motion_ctrl #(.FRAME_DIV(3)) dut3 (
      .clock(clock), .reset(reset), .enable(enable), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .pause(pause), .step(step), .obj_x(ox1), .obj_y(oy1), .dir_x(dx1), .dir_y(dy1),
      .obj_on(on1), .red(r1), .green(g1), .blue(b1), .frame_count(fc1));

   task automatic check(input string name, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic check_mv(input string name, input mv_t got, input mv_t exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got fc=%0d x=%0d y=%0d dx=%0d dy=%0d expected fc=%0d x=%0d y=%0d dx=%0d dy=%0d",
                  name, got.fc, got.x, got.y, got.dx, got.dy, exp.fc, exp.x, exp.y, exp.dx, exp.dy);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mx[i] = 300; my[i] = 220; mdx[i] = 1; mdy[i] = 1; mcnt[i] = 0;
      end
      mfc = 0;
      armed = 1'b0;
   endtask

   // Bounce rule: land on the far edge and turn around when a step would overshoot.
   task automatic move_axis(inout int pos, inout int dir, input int stp, input int lim);
      if (dir == 1) begin
         if (pos + stp + 40 > lim) begin pos = lim - 40; dir = 0; end
         else pos = pos + stp;
      end else begin
         if (pos - stp < 0) begin pos = 0; dir = 1; end
         else pos = pos - stp;
      end
   endtask

   task automatic model_frame();
      mv_t e;
      mfc = (mfc + 1) % 256;
      for (int i = 0; i < 2; i++) begin
         if (!pause) begin
            mcnt[i] = mcnt[i] + 1;
            if (mcnt[i] == fdv[i]) begin
               mcnt[i] = 0;
               move_axis(mx[i], mdx[i], int'(step), 640);
               move_axis(my[i], mdy[i], int'(step), 480);
            end
         end
         e.fc = 8'(mfc); e.x = 10'(mx[i]); e.y = 10'(my[i]);
         e.dx = 1'(mdx[i]); e.dy = 1'(mdy[i]);
         if (i == 0) mq0.push_back(e);
         else        mq1.push_back(e);
      end
   endtask

   function automatic bit in_sq(input int i, input int x, input int y);
      return (x >= mx[i]) && (x < mx[i] + 40) && (y >= my[i]) && (y < my[i] + 40);
   endfunction

   task automatic tick(input int x, input int y, input bit en);
      px_t p;
      @(negedge clock);
      pixel_x = 10'(x);
      pixel_y = 10'(y);
      enable  = en;
      if (en) begin
         p.on0  = in_sq(0, x, y);
         p.rgb0 = p.on0 ? 24'hFFFFFF : 24'h000000;
         p.on1  = in_sq(1, x, y);
         p.rgb1 = p.on1 ? 24'hFFFFFF : 24'h000000;
         pq.push_back(p);
      end
      if (y < 480) armed = 1'b1;
      else if (en && armed) begin
         armed = 1'b0;
         model_frame();
      end
   endtask

   // One pixel tick followed by idle clocks with a different column (outputs must hold).
   task automatic pixel(input int x, input int y);
      tick(x, y, 1'b1);
      repeat (($urandom_range(0, 3) == 0) ? 3 : 1) tick(int'($urandom_range(0, 1023)), y, 1'b0);
   endtask

   function automatic int near(input int base, input int hi);
      int v;
      v = base + int'($urandom_range(0, 49)) - 5;
      if (v < 0) v = 0;
      if (v > hi) v = hi;
      return v;
   endfunction

   task automatic frame();
      for (int k = 0; k < 4; k++) begin
         if ($urandom_range(0, 1) == 0) pixel(near(mx[k % 2], 639), near(my[k % 2], 479));
         else pixel(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
      end
      for (int k = 0; k < int'($urandom_range(4, 7)); k++)
         pixel(int'($urandom_range(0, 639)), int'($urandom_range(480, 524)));
   endtask

   // Motion monitor: a frame_count change means an update sequence has started.
   int   cd = 0;
   logic [7:0] fc_seen = 8'd0;
   always @(negedge clock) begin
      mv_t e;
      if (reset) begin
         cd = 0;
         fc_seen = 8'd0;
      end else begin
         if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) begin
               if (mq0.size() == 0 || mq1.size() == 0) begin
                  check("motion_unexpected", int'(fc0), int'(fc_seen) - 1);
               end else begin
                  e = mq0.pop_front();
                  check_mv("motion_div1", {fc0, ox0, oy0, dx0, dy0}, e);
                  e = mq1.pop_front();
                  check_mv("motion_div3", {fc1, ox1, oy1, dx1, dy1}, e);
               end
            end
         end
         if (fc0 != fc_seen) begin
            fc_seen = fc0;
            cd = 2;
         end
      end
   end

   // Pixel monitor: new value one enable later, otherwise the last value held.
   bit  en_seen = 1'b0;
   px_t last = '0;
   always @(posedge clock) en_seen = enable && !reset;
   always @(negedge clock) begin
      if (reset) begin
         last = '0;
      end else begin
         if (en_seen) begin
            if (pq.size() == 0) check("pixel_unexpected", 1, 0);
            else last = pq.pop_front();
         end
         check("pixel_div1", int'({on0, r0, g0, b0}), int'({last.on0, last.rgb0}));
         check("pixel_div3", int'({on1, r1, g1, b1}), int'({last.on1, last.rgb1}));
      end
   end

   task automatic check_reset_state(input string tag);
      check({tag, "_x"}, int'(ox0), 300);
      check({tag, "_y"}, int'(oy0), 220);
      check({tag, "_dir"}, int'({dx0, dy0}), 3);
      check({tag, "_fc"}, int'(fc0), 0);
      check({tag, "_rgb"}, int'({on0, r0, g0, b0}), 0);
   endtask

   initial begin
      int t;
      reset = 1'b1; enable = 1'b0; pause = 1'b0; step = 3'd1;
      pixel_x = 10'd0; pixel_y = 10'd500;
      model_reset();
      repeat (3) @(negedge clock);
      check_reset_state("reset");
      reset = 1'b0;

      // reset-position pixel hits and misses
      pixel(300, 220); pixel(340, 220); pixel(339, 259); pixel(299, 220); pixel(300, 260);

      repeat (3) frame();
      @(negedge clock);
      check("three_frames_x", int'(ox0), 303);
      check("three_frames_y", int'(oy0), 223);
      check("three_frames_fc", int'(fc0), 3);
      check("three_frames_div3_x", int'(ox1), 301);

      for (int f = 0; f < 600; f++) begin
         @(negedge clock);
         step  = 3'($urandom_range(0, 7));
         pause = ($urandom_range(0, 5) == 0);
         frame();
         if (f == 300) begin
            // reset while the update sequence is in UPDATE_X
            pixel(100, 100);
            tick(100, 500, 1'b1);
            @(posedge clock);
            #2;
            reset = 1'b1;
            pq.delete(); mq0.delete(); mq1.delete();
            model_reset();
            @(negedge clock);
            check_reset_state("mid_reset");
            tick(0, 500, 1'b0);
            tick(0, 500, 1'b0);
            @(negedge clock);
            reset = 1'b0;
            repeat (10) pixel(int'($urandom_range(0, 639)), 500);
            check("after_reset_fc", int'(fc0), 0);
            check("after_reset_x", int'(ox0), 300);
         end
      end

      t = 0;
      while ((mq0.size() != 0 || pq.size() != 0) && t < 50) begin
         @(negedge clock);
         t++;
      end
      check("drain_timeout", int'(mq0.size() + pq.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
